ft_recovery_ctrl: RTL and testbench
===================================

Name: ft_recovery_ctrl

Overview:
Fault-recovery sequencer for the dual-core fault-tolerant SoC. It gates fetch enable to both cores and checks the pair for divergence, either a lockstep PC mismatch at retire or an injected error pulse. On divergence it halts and drains the cores, then rolls both back to the last agreed checkpoint PC. It bounds retries and declares a sticky failure when they are exhausted. It sits between the SoC fetch_enable input and the cores' fetch-enable, halt and PC-restore inputs.

Parameters:
ADDR_W, 32, width of instruction addresses
BOOT_ADDR, 32'h0000_0080, checkpoint PC after reset
DRAIN_MAX, 16, maximum cycles spent waiting for the cores to go idle before forcing a restore
MAX_RETRY, 3, consecutive recoveries allowed before FAIL
CLEAN_RUN, 32, error-free retires that clear the retry counter
RESUME_CYC, 2, cycles between the restore pulse and re-enabling fetch

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
fetch_enable_i  in  1  SoC-level fetch request
error_i  in  1  external error or injection pulse
retire_i  in  1  both cores retired one instruction this cycle
pc0_i  in  ADDR_W  retired PC of core 0
pc1_i  in  ADDR_W  retired PC of core 1
core_busy_i  in  2  per-core pipeline busy flags
fetch_enable_o  out  1  fetch enable to both cores
halt_o  out  1  halt request to both cores
restore_o  out  1  one-cycle PC-restore strobe
restore_pc_o  out  ADDR_W  PC to restore, valid while restore_o is high
recov_cnt_o  out  8  total recoveries, saturating at 255
fail_o  out  1  sticky unrecoverable-fault flag
state_o  out  3  current FSM state encoding

Behaviour:
- Reset values: fetch_enable_o=0, halt_o=0, restore_o=0, restore_pc_o=BOOT_ADDR, recov_cnt_o=0, fail_o=0, state=IDLE. Internally ckpt_pc=BOOT_ADDR and retry_cnt, clean_cnt and timer are 0. Reset mid-operation in any state, including FAIL, returns to these values on the next edge.
- All outputs are registered. An FSM transition and its outputs take effect on the same clock edge.
- Mismatch definition: mismatch = error_i | (retire_i & (pc0_i != pc1_i)).
- IDLE (0):
  - Outputs all low.
  - fetch_enable_i=1 -> RUN, and fetch_enable_o=1 on that edge.
  - error_i in IDLE is ignored.
- RUN (1):
  - Retire with no mismatch: ckpt_pc <= pc0_i and clean_cnt increments. When clean_cnt reaches CLEAN_RUN-1 and another clean retire occurs, retry_cnt<=0 and clean_cnt<=0.
  - Retire with a mismatch in the same cycle: ckpt_pc is NOT updated.
  - Mismatch -> DRAIN: fetch_enable_o<=0, halt_o<=1, timer<=0, clean_cnt<=0.
  - fetch_enable_i=0 with no mismatch -> IDLE: fetch_enable_o<=0. A mismatch takes priority over fetch_enable_i=0.
- DRAIN (2):
  - timer increments each cycle.
  - Exit condition: core_busy_i==2'b00, or timer==DRAIN_MAX-1.
  - On exit, if retry_cnt==MAX_RETRY -> FAIL; otherwise -> RESTORE.
- RESTORE (3):
  - Exactly one cycle with restore_o=1 and restore_pc_o=ckpt_pc.
  - retry_cnt increments; recov_cnt_o increments, saturating at 255.
  - -> RESUME with timer<=0.
- RESUME (4):
  - halt_o stays high for RESUME_CYC cycles.
  - Then -> RUN with halt_o<=0 and fetch_enable_o<=fetch_enable_i. If fetch_enable_i=0 at that point -> IDLE instead.
- FAIL (5):
  - fail_o=1, halt_o=1, fetch_enable_o=0.
  - Left only by reset.
- error_i and PC mismatches during DRAIN, RESTORE, RESUME and FAIL are ignored: there is no queuing.
- restore_pc_o holds its last value outside RESTORE.
- Counters never wrap: retry_cnt is bounded by MAX_RETRY and recov_cnt_o saturates.

Decomposition:
- Package ft_ctrl_pkg:
  - state enum ft_state_e {IDLE, RUN, DRAIN, RESTORE, RESUME, FAIL} with 3-bit encoding as above.
  - Localparam widths for the timer, retry and clean counters, derived with $clog2 of DRAIN_MAX, MAX_RETRY+1 and CLEAN_RUN.
- Sub-module ft_checkpoint_reg:
  - Holds ckpt_pc and the clean_cnt / retry-clear logic.
  - The FSM and counters stay in the top module.

Test Plan:
- Reset then fetch_enable_i=1 -> fetch_enable_o=1 one cycle later, state_o=1. Retire 5 matching PCs ending at 0x94 -> ckpt_pc=0x94, no halt.
- Retire with pc0_i=0x98, pc1_i=0x9C -> next cycle halt_o=1 and fetch_enable_o=0. After core_busy_i goes low, one restore_o pulse with restore_pc_o=0x94. halt_o drops 2 cycles later and recov_cnt_o=1.
- error_i pulse in RUN while core_busy_i stays 2'b11 -> forced restore after exactly 16 DRAIN cycles.
- Four back-to-back error_i events with no clean retires between them -> three restores, then FAIL: fail_o=1 permanently, recov_cnt_o=3. rst_i=1 for one cycle clears everything.
- Three recoveries, then 32 clean retires, then an error -> a 4th restore occurs with no FAIL, because the retry counter was cleared.
- Mismatching retire with error_i high in the same cycle -> ckpt_pc unchanged. error_i asserted during RESUME -> ignored, recov_cnt_o increments by only 1.

Source files
------------

// File: rtl/ft_ctrl_pkg.sv
// Shared types and default sizing for the dual-core fault-recovery sequencer.
package ft_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUN     = 3'd1,
      DRAIN   = 3'd2,
      RESTORE = 3'd3,
      RESUME  = 3'd4,
      FAIL    = 3'd5
   } ft_state_e;

   localparam int          ADDR_W_DEF     = 32;
   localparam logic [31:0] BOOT_ADDR_DEF  = 32'h0000_0080;
   localparam int          DRAIN_MAX_DEF  = 16;
   localparam int          MAX_RETRY_DEF  = 3;
   localparam int          CLEAN_RUN_DEF  = 32;
   localparam int          RESUME_CYC_DEF = 2;

   // Bits needed to count 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int TIMER_W = cnt_w(DRAIN_MAX_DEF);
   localparam int RETRY_W = cnt_w(MAX_RETRY_DEF + 1);
   localparam int CLEAN_W = cnt_w(CLEAN_RUN_DEF);

endpackage

// File: rtl/ft_recovery_ctrl_if.sv
// Core-side connection of the recovery sequencer: retire/PC compare inputs and fetch/halt/restore controls.
interface ft_recovery_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              retire_i;
   logic [ADDR_W-1:0] pc0_i;
   logic [ADDR_W-1:0] pc1_i;
   logic [1:0]        core_busy_i;
   logic              fetch_enable_o;
   logic              halt_o;
   logic              restore_o;
   logic [ADDR_W-1:0] restore_pc_o;

   modport master (
      input  retire_i, pc0_i, pc1_i, core_busy_i,
      output fetch_enable_o, halt_o, restore_o, restore_pc_o
   );

   modport slave (
      output retire_i, pc0_i, pc1_i, core_busy_i,
      input  fetch_enable_o, halt_o, restore_o, restore_pc_o
   );
endinterface

// File: rtl/ft_checkpoint_reg.sv
// Last agreed checkpoint PC plus the clean-retire run counter that forgives earlier retries.
module ft_checkpoint_reg #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BOOT_ADDR = ADDR_W'(32'h80),
   parameter int                CLEAN_RUN = 32,
   parameter int                CLEAN_W   = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              run_i,
   input  logic              retire_i,
   input  logic              mismatch_i,
   input  logic [ADDR_W-1:0] pc_i,
   output logic [ADDR_W-1:0] ckpt_pc_o,
   output logic              retry_clr_o
);

   logic [CLEAN_W-1:0] clean_q;
   logic               clean_retire;

   assign clean_retire = run_i & retire_i & ~mismatch_i;
   assign retry_clr_o  = clean_retire & (clean_q == CLEAN_W'(CLEAN_RUN - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ckpt_pc_o <= BOOT_ADDR;
         clean_q   <= '0;
      end else if (clean_retire) begin
         ckpt_pc_o <= pc_i;
         clean_q   <= retry_clr_o ? '0 : clean_q + CLEAN_W'(1);
      end else if (run_i & mismatch_i) begin
         // a divergence breaks the clean run; the checkpoint itself is kept
         clean_q   <= '0;
      end
   end

endmodule

// File: rtl/ft_recovery_ctrl.sv
// Lockstep divergence detector and rollback sequencer for the dual-core pair.
//   state   | meaning
//   IDLE    | fetch gated off, waiting for SoC fetch enable
//   RUN     | cores fetching, retires compared and checkpointed
//   DRAIN   | halted, waiting for both pipelines idle (bounded)
//   RESTORE | one-cycle PC restore strobe to last checkpoint
//   RESUME  | halt held for a few cycles before refetch
//   FAIL    | retries exhausted, halted until reset
module ft_recovery_ctrl
   import ft_ctrl_pkg::*;
#(
   parameter int                ADDR_W     = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] BOOT_ADDR  = ADDR_W'(BOOT_ADDR_DEF),
   parameter int                DRAIN_MAX  = DRAIN_MAX_DEF,
   parameter int                MAX_RETRY  = MAX_RETRY_DEF,
   parameter int                CLEAN_RUN  = CLEAN_RUN_DEF,
   parameter int                RESUME_CYC = RESUME_CYC_DEF
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                fetch_enable_i,
   input  logic                error_i,
   ft_recovery_ctrl_if.master  core,
   output logic [7:0]          recov_cnt_o,
   output logic                fail_o,
   output logic [2:0]          state_o
);

   ft_state_e          state_q, state_d;
   logic               fe_q, fe_d;
   logic               halt_q, halt_d;
   logic               restore_q, restore_d;
   logic [ADDR_W-1:0]  rpc_q, rpc_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic [7:0]         recov_q, recov_d;
   logic               fail_q, fail_d;

   logic               mismatch;
   logic               retry_clr;
   logic [ADDR_W-1:0]  ckpt_pc;

   assign mismatch = error_i | (core.retire_i & (core.pc0_i != core.pc1_i));

   ft_checkpoint_reg #(
      .ADDR_W    (ADDR_W),
      .BOOT_ADDR (BOOT_ADDR),
      .CLEAN_RUN (CLEAN_RUN),
      .CLEAN_W   (CLEAN_W)
   ) u_ckpt (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .run_i       (state_q == RUN),
      .retire_i    (core.retire_i),
      .mismatch_i  (mismatch),
      .pc_i        (core.pc0_i),
      .ckpt_pc_o   (ckpt_pc),
      .retry_clr_o (retry_clr)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         fe_q      <= 1'b0;
         halt_q    <= 1'b0;
         restore_q <= 1'b0;
         rpc_q     <= BOOT_ADDR;
         timer_q   <= '0;
         retry_q   <= '0;
         recov_q   <= '0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         fe_q      <= fe_d;
         halt_q    <= halt_d;
         restore_q <= restore_d;
         rpc_q     <= rpc_d;
         timer_q   <= timer_d;
         retry_q   <= retry_d;
         recov_q   <= recov_d;
         fail_q    <= fail_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      fe_d      = fe_q;
      halt_d    = halt_q;
      restore_d = 1'b0;
      rpc_d     = rpc_q;
      timer_d   = timer_q;
      retry_d   = retry_q;
      recov_d   = recov_q;
      fail_d    = fail_q;

      case (state_q)
         IDLE: begin
            if (fetch_enable_i) begin
               state_d = RUN;
               fe_d    = 1'b1;
            end
         end
         RUN: begin
            if (retry_clr) retry_d = '0;
            if (mismatch) begin
               state_d = DRAIN;
               fe_d    = 1'b0;
               halt_d  = 1'b1;
               timer_d = TIMER_W'(DRAIN_MAX - 1);
            end else if (!fetch_enable_i) begin
               state_d = IDLE;
               fe_d    = 1'b0;
            end
         end
         DRAIN: begin
            // timer counts down the remaining drain budget
            if (core.core_busy_i == 2'b00 || timer_q == '0) begin
               if (retry_q == RETRY_W'(MAX_RETRY)) begin
                  state_d = FAIL;
                  fail_d  = 1'b1;
               end else begin
                  state_d   = RESTORE;
                  restore_d = 1'b1;
                  rpc_d     = ckpt_pc;
               end
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         RESTORE: begin
            state_d = RESUME;
            timer_d = TIMER_W'(RESUME_CYC - 1);
            retry_d = retry_q + RETRY_W'(1);
            if (recov_q != 8'hFF) recov_d = recov_q + 8'd1;
         end
         RESUME: begin
            if (timer_q == '0) begin
               halt_d  = 1'b0;
               fe_d    = fetch_enable_i;
               state_d = fetch_enable_i ? RUN : IDLE;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         FAIL: begin
            fail_d = 1'b1;
            halt_d = 1'b1;
            fe_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   assign core.fetch_enable_o = fe_q;
   assign core.halt_o         = halt_q;
   assign core.restore_o      = restore_q;
   assign core.restore_pc_o   = rpc_q;
   assign recov_cnt_o         = recov_q;
   assign fail_o              = fail_q;
   assign state_o             = state_q;

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Directed bench for ft_recovery_ctrl: a cycle model of the recovery rules checked every cycle, plus pinned literals.
module tb_ft_recovery_ctrl;

   localparam int DRAIN_MAX  = 16;
   localparam int MAX_RETRY  = 3;
   localparam int CLEAN_RUN  = 32;
   localparam int RESUME_CYC = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       fe_in;
   logic       err;
   logic [7:0] recov;
   logic       fail;
   logic [2:0] state;

   always #5 clk = ~clk;

   ft_recovery_ctrl_if #(.ADDR_W(32)) cif ();

   ft_recovery_ctrl #(
      .ADDR_W     (32),
      .BOOT_ADDR  (32'h80),
      .DRAIN_MAX  (DRAIN_MAX),
      .MAX_RETRY  (MAX_RETRY),
      .CLEAN_RUN  (CLEAN_RUN),
      .RESUME_CYC (RESUME_CYC)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .fetch_enable_i (fe_in),
      .error_i        (err),
      .core           (cif),
      .recov_cnt_o    (recov),
      .fail_o         (fail),
      .state_o        (state)
   );

   int n_vec = 0;
   int n_err = 0;
   logic chk_en = 1'b0;

   // model: mode uses the published state numbering; everything else is plain arithmetic
   int          m_mode, m_age, m_clean, m_retry, m_recov;
   logic [31:0] m_ckpt, m_rpc;

   task automatic model_step();
      bit mm;
      if (rst) begin
         m_mode = 0; m_age = 0; m_clean = 0; m_retry = 0; m_recov = 0;
         m_ckpt = 32'h80; m_rpc = 32'h80;
         return;
      end
      mm = err || (cif.retire_i && (cif.pc0_i != cif.pc1_i));
      case (m_mode)
         0: if (fe_in) m_mode = 1;
         1: begin
            if (cif.retire_i && !mm) begin
               m_ckpt = cif.pc0_i;
               m_clean++;
               if (m_clean == CLEAN_RUN) begin m_clean = 0; m_retry = 0; end
            end
            if (mm) begin m_clean = 0; m_mode = 2; m_age = 0; end
            else if (!fe_in) m_mode = 0;
         end
         2: begin
            m_age++;
            if (cif.core_busy_i == 2'b00 || m_age == DRAIN_MAX) begin
               if (m_retry == MAX_RETRY) m_mode = 5;
               else begin m_mode = 3; m_rpc = m_ckpt; end
            end
         end
         3: begin
            m_retry++;
            if (m_recov < 255) m_recov++;
            m_mode = 4; m_age = 0;
         end
         4: begin
            m_age++;
            if (m_age == RESUME_CYC) m_mode = fe_in ? 1 : 0;
         end
         default: ;
      endcase
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         logic e_fe, e_halt, e_rs, e_fail;
         e_fe   = (m_mode == 1);
         e_halt = (m_mode >= 2 && m_mode <= 5);
         e_rs   = (m_mode == 3);
         e_fail = (m_mode == 5);
         n_vec++;
         if (state !== 3'(m_mode) || cif.fetch_enable_o !== e_fe || cif.halt_o !== e_halt ||
             cif.restore_o !== e_rs || fail !== e_fail || recov !== 8'(m_recov) ||
             cif.restore_pc_o !== m_rpc) begin
            n_err++;
            $display("FAIL cycle_outputs t=%0t: got st=%0d fe=%b halt=%b rs=%b fail=%b recov=%0d pc=%h, expected st=%0d fe=%b halt=%b rs=%b fail=%b recov=%0d pc=%h",
                     $time, state, cif.fetch_enable_o, cif.halt_o, cif.restore_o, fail, recov,
                     cif.restore_pc_o, m_mode, e_fe, e_halt, e_rs, e_fail, m_recov, m_rpc);
         end
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
      int n = 0;
      while (state !== s && n < budget) begin
         tick();
         n++;
      end
      check(nm, 64'(state), 64'(s));
   endtask

   task automatic retire(input logic [31:0] a, input logic [31:0] b, input logic e);
      cif.retire_i = 1'b1; cif.pc0_i = a; cif.pc1_i = b; err = e;
      tick();
      cif.retire_i = 1'b0; err = 1'b0;
   endtask

   task automatic recover(input string nm);
      err = 1'b1;
      tick();
      err = 1'b0;
      wait_state(3'd1, 60, nm);
   endtask

   task automatic clean_run(input logic [31:0] base);
      for (int k = 0; k < CLEAN_RUN; k++) retire(base + 32'(4 * k), base + 32'(4 * k), 1'b0);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: run did not complete, time %0t", $time);
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1; fe_in = 1'b0; err = 1'b0;
      cif.retire_i = 1'b0; cif.pc0_i = '0; cif.pc1_i = '0; cif.core_busy_i = 2'b11;
      tick(); tick();
      chk_en = 1'b1;
      check("reset_state", 64'(state), 64'd0);
      check("reset_restore_pc", 64'(cif.restore_pc_o), 64'h80);
      check("reset_fetch", 64'(cif.fetch_enable_o), 64'd0);
      rst = 1'b0;

      // fetch enable and five matching retires
      fe_in = 1'b1;
      tick();
      check("run_state", 64'(state), 64'd1);
      check("run_fetch", 64'(cif.fetch_enable_o), 64'd1);
      for (int k = 1; k <= 5; k++) retire(32'h80 + 32'(4 * k), 32'h80 + 32'(4 * k), 1'b0);
      check("no_halt_after_retires", 64'(cif.halt_o), 64'd0);

      // PC mismatch at retire
      retire(32'h98, 32'h9C, 1'b0);
      check("mismatch_halt", 64'(cif.halt_o), 64'd1);
      check("mismatch_fetch_off", 64'(cif.fetch_enable_o), 64'd0);
      tick(); tick();
      cif.core_busy_i = 2'b00;
      wait_state(3'd3, 20, "reach_restore");
      check("restore_strobe", 64'(cif.restore_o), 64'd1);
      check("restore_pc_0x94", 64'(cif.restore_pc_o), 64'h94);
      tick();
      check("resume_state", 64'(state), 64'd4);
      tick(); tick();
      check("resume_exit_run", 64'(state), 64'd1);
      check("halt_dropped", 64'(cif.halt_o), 64'd0);
      check("recov_one", 64'(recov), 64'd1);

      // forced restore when the cores never go idle
      cif.core_busy_i = 2'b11;
      err = 1'b1;
      tick();
      err = 1'b0;
      n = 0;
      while (state === 3'd2 && n < 40) begin
         n++;
         tick();
      end
      check("drain_cycles", 64'(n), 64'd16);
      check("forced_restore", 64'(state), 64'd3);
      wait_state(3'd1, 10, "back_to_run_after_forced");

      // retry exhaustion
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cif.core_busy_i = 2'b00;
      wait_state(3'd1, 5, "run_after_reset");
      for (int i = 0; i < 3; i++) recover("retry_recover");
      err = 1'b1;
      tick();
      err = 1'b0;
      wait_state(3'd5, 10, "enter_fail");
      check("fail_flag", 64'(fail), 64'd1);
      check("fail_recov_three", 64'(recov), 64'd3);
      err = 1'b1;
      repeat (3) tick();
      err = 1'b0;
      repeat (3) tick();
      check("fail_sticky", 64'(fail), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("fail_cleared", 64'(fail), 64'd0);
      check("recov_cleared", 64'(recov), 64'd0);
      check("state_idle_after_reset", 64'(state), 64'd0);

      // clean run forgives earlier retries
      wait_state(3'd1, 5, "run_again");
      for (int i = 0; i < 3; i++) recover("pre_clean_recover");
      clean_run(32'h100);
      err = 1'b1;
      tick();
      err = 1'b0;
      wait_state(3'd3, 10, "fourth_restore");
      check("fourth_restore_pc", 64'(cif.restore_pc_o), 64'h17C);
      wait_state(3'd1, 10, "run_after_fourth");
      check("recov_four", 64'(recov), 64'd4);
      check("no_fail_after_clean", 64'(fail), 64'd0);

      // mismatch + error on the same retire, then error during RESUME
      retire(32'h200, 32'h204, 1'b1);
      wait_state(3'd3, 10, "restore_same_cycle");
      check("ckpt_not_updated", 64'(cif.restore_pc_o), 64'h17C);
      wait_state(3'd4, 5, "reach_resume");
      err = 1'b1;
      tick();
      err = 1'b0;
      wait_state(3'd1, 10, "resume_err_ignored");
      tick(); tick();
      check("recov_five", 64'(recov), 64'd5);
      check("still_run", 64'(state), 64'd1);

      // fetch enable drop and error in IDLE
      fe_in = 1'b0;
      tick();
      check("idle_on_fe_low", 64'(state), 64'd0);
      err = 1'b1;
      tick();
      err = 1'b0;
      tick();
      check("idle_ignores_error", 64'(state), 64'd0);
      fe_in = 1'b1;
      wait_state(3'd1, 5, "run_before_sat");

      // recovery counter saturation
      clean_run(32'h300);
      for (int g = 0; g < 87; g++) begin
         for (int r = 0; r < 3; r++) recover("sat_recover");
         clean_run(32'h400);
      end
      check("recov_saturated", 64'(recov), 64'd255);
      check("sat_no_fail", 64'(fail), 64'd0);

      // reset in the middle of DRAIN
      cif.core_busy_i = 2'b11;
      err = 1'b1;
      tick();
      err = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_drain_reset_state", 64'(state), 64'd0);
      check("mid_drain_reset_recov", 64'(recov), 64'd0);
      check("mid_drain_reset_pc", 64'(cif.restore_pc_o), 64'h80);
      tick(); tick();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
